// File: rtl/gpu_blit_cmdq.sv
// gpu_blit_cmdq: Wishbone command queue that feeds rectangle descriptors to the GPU blitter
// Ports: clk/rst_n (async active-low); wb_* Wishbone slave for staging, PUSH and STATUS;
// m_* Wishbone master that writes the blitter register window; blit_busy from the blitter;
// busy high while commands are queued or one is in flight.
module gpu_blit_cmdq #(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] BLIT_BASE = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   output logic        m_cyc_o,
   output logic        m_stb_o,
   output logic        m_we_o,
   output logic [3:0]  m_sel_o,
   output logic [31:0] m_adr_o,
   output logic [31:0] m_dat_o,
   input  logic        m_ack_i,
   input  logic        blit_busy,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [2:0] {IDLE, LOAD, WR, WAIT_ACK, SETTLE, WAIT_DONE} state_e;
   state_e        state_q;
   logic [161:0]  mem_q [DEPTH];
   logic [161:0]  cmd_q;
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   x_q, y_q, w_q, h_q, pat_q, rdat_d, rdat_q, seq_dat;
   logic [3:0]    a, seq_adr;
   logic [2:0]    k_q;
   logic          ack_q, ovf_q, acc, wr, push, push_ok, pop, full, empty, unused;
   assign a        = wb_adr_i[3:0];
   assign acc      = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wr       = acc & wb_we_i;
   assign full     = count_q == CW'(DEPTH);
   assign empty    = count_q == '0;
   assign push     = wr & (a == 4'd5);
   // full is judged before any same-cycle pop, so a push into a full queue is always dropped
   assign push_ok  = push & ~full;
   assign pop      = state_q == LOAD;
   assign count_d  = count_q + CW'(push_ok) - CW'(pop);
   assign busy     = ~empty | (state_q != IDLE);
   assign wb_ack_o = ack_q;
   assign wb_dat_o = rdat_q;
   assign unused   = ^{wb_sel_i, wb_adr_i[31:4]};
   always_comb begin
      rdat_d = a == 4'd0 ? x_q :
               a == 4'd1 ? y_q :
               a == 4'd2 ? w_q :
               a == 4'd3 ? h_q :
               a == 4'd4 ? pat_q :
               a == 4'd6 ? {16'h0, 8'(count_q), 4'h0, ovf_q, empty, full, busy} : 32'h0;
   end
   // write order: X, Y, W, H, PATTERN to regs 2..6, then the start word to reg 0
   always_comb begin
      seq_adr = k_q < 3'd5 ? 4'(k_q) + 4'd2 : 4'd0;
      seq_dat = k_q == 3'd0 ? cmd_q[161:130] :
                k_q == 3'd1 ? cmd_q[129:98] :
                k_q == 3'd2 ? cmd_q[97:66] :
                k_q == 3'd3 ? cmd_q[65:34] :
                k_q == 3'd4 ? cmd_q[33:2] : {29'h0, cmd_q[1:0], 1'b1};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q  <= 1'b0;
         rdat_q <= '0;
         x_q    <= '0;
         y_q    <= '0;
         w_q    <= '0;
         h_q    <= '0;
         pat_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ack_q  <= acc;
         rdat_q <= acc ? rdat_d : 32'h0;
         if (wr && a == 4'd0) x_q <= wb_dat_i;
         if (wr && a == 4'd1) y_q <= wb_dat_i;
         if (wr && a == 4'd2) w_q <= wb_dat_i;
         if (wr && a == 4'd3) h_q <= wb_dat_i;
         if (wr && a == 4'd4) pat_q <= wb_dat_i;
         if (push && full) ovf_q <= 1'b1;
         else if (wr && a == 4'd6 && wb_dat_i[3]) ovf_q <= 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= {x_q, y_q, w_q, h_q, pat_q, wb_dat_i[2:1]};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop) rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         k_q     <= '0;
         m_cyc_o <= 1'b0;
         m_stb_o <= 1'b0;
         m_we_o  <= 1'b0;
         m_sel_o <= '0;
         m_adr_o <= '0;
         m_dat_o <= '0;
      end else begin
         case (state_q)
            IDLE: if (!empty && !blit_busy) state_q <= LOAD;
            LOAD: begin
               cmd_q   <= mem_q[rptr_q];
               k_q     <= '0;
               state_q <= WR;
            end
            WR: begin
               m_cyc_o <= 1'b1;
               m_stb_o <= 1'b1;
               m_we_o  <= 1'b1;
               m_sel_o <= 4'hF;
               m_adr_o <= BLIT_BASE + 32'(seq_adr);
               m_dat_o <= seq_dat;
               state_q <= WAIT_ACK;
            end
            WAIT_ACK: if (m_ack_i) begin
               m_cyc_o <= 1'b0;
               m_stb_o <= 1'b0;
               m_we_o  <= 1'b0;
               k_q     <= k_q + 3'd1;
               state_q <= k_q < 3'd5 ? WR : SETTLE;
            end
            // blit_busy is not valid yet in the cycle after the start write
            SETTLE: state_q <= WAIT_DONE;
            WAIT_DONE: if (!blit_busy) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gpu_blit_cmdq.sv
// tb_gpu_blit_cmdq: randomized directed bench for gpu_blit_cmdq against a queue-based reference model
module tb_gpu_blit_cmdq;
   localparam int          DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [3:0]  wb_sel_i = 4'hF;
   logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i = 1'b0;
   logic [3:0]  m_sel_o;
   logic [31:0] m_adr_o, m_dat_o;
   logic        blit_busy, busy;
   int          vecs = 0, errs = 0, nacc = 0, nstart = 0, rd_idx = 0, nwr = 0;
   int          ack_lat = 0, busy_len = 20, bcnt = 0, wcnt = 0, snap;
   logic        hold_busy = 1'b0, kick = 1'b0, in_xfer = 1'b0, movf = 1'b0, got;
   logic [31:0] sx = '0, sy = '0, sw = '0, sh = '0, sp = '0, cap_adr, cap_dat, q;
   logic [63:0] exp_q [$];
   always #5 clk = ~clk;
   assign blit_busy = hold_busy | (bcnt != 0);
   gpu_blit_cmdq #(.DEPTH(DEPTH), .BLIT_BASE(BASE)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
      .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i),
      .blit_busy(blit_busy), .busy(busy)
   );
   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] stat_exp();
      int p = nacc - nstart;
      return {16'h0, 8'(p), 4'h0, movf, p == 0, p == DEPTH, p != 0};
   endfunction
   task automatic wb_xfer(input logic we, input logic [3:0] a, input logic [31:0] d, output logic [31:0] r);
      logic ok = 1'b0;
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = {28'h5A5A5A5, a}; wb_dat_i = d;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (wb_ack_o) begin ok = 1'b1; break; end
      end
      r = wb_dat_o;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      chk("wb_ack", ok, 1'b1);
   endtask
   task automatic stage(input logic [31:0] x, y, w, h, p);
      wb_xfer(1'b1, 4'd0, x, q); wb_xfer(1'b1, 4'd1, y, q); wb_xfer(1'b1, 4'd2, w, q);
      wb_xfer(1'b1, 4'd3, h, q); wb_xfer(1'b1, 4'd4, p, q);
      sx = x; sy = y; sw = w; sh = h; sp = p;
   endtask
   task automatic push(input logic [31:0] ctl);
      wb_xfer(1'b1, 4'd5, ctl, q);
      if (nacc - nstart >= DEPTH) movf = 1'b1;
      else begin
         exp_q.push_back({BASE + 32'd2, sx}); exp_q.push_back({BASE + 32'd3, sy});
         exp_q.push_back({BASE + 32'd4, sw}); exp_q.push_back({BASE + 32'd5, sh});
         exp_q.push_back({BASE + 32'd6, sp}); exp_q.push_back({BASE, 29'h0, ctl[2], ctl[1], 1'b1});
         nacc++;
      end
   endtask
   task automatic wait_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!busy && !blit_busy) break;
      end
      chk("drain", {busy, blit_busy}, 2'b00);
      chk("all_writes", 32'(rd_idx), 32'(exp_q.size()));
   endtask
   // master-side ack responder with programmable latency
   initial forever begin
      @(posedge clk); #1;
      if (m_ack_i) m_ack_i = 1'b0;
      else if (!(m_cyc_o && m_stb_o)) wcnt = 0;
      else if (wcnt >= ack_lat) begin m_ack_i = 1'b1; wcnt = 0; end
      else wcnt++;
   end
   // blitter model: busy for busy_len cycles after each start write
   initial forever begin
      @(posedge clk); #1;
      if (!rst_n) begin bcnt = 0; kick = 1'b0; end
      else if (kick) begin bcnt = busy_len; kick = 1'b0; end
      else if (bcnt > 0) bcnt--;
   end
   // master bus monitor and scoreboard
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         in_xfer = 1'b0; rd_idx = exp_q.size(); nstart = nacc;
      end else if (m_cyc_o && m_stb_o) begin
         if (!in_xfer) begin
            in_xfer = 1'b1; cap_adr = m_adr_o; cap_dat = m_dat_o;
            chk("m_we_sel", {m_we_o, m_sel_o}, 5'h1F);
            if (rd_idx % 6 == 0) begin
               nstart++;
               chk("start_while_blit_busy", blit_busy, 1'b0);
            end
         end else chk("m_hold", {m_adr_o, m_dat_o, m_we_o, m_sel_o}, {cap_adr, cap_dat, 5'h1F});
         if (m_ack_i) begin
            in_xfer = 1'b0; nwr++;
            chk("write_expected", rd_idx < exp_q.size(), 1'b1);
            if (rd_idx < exp_q.size()) begin
               chk("m_write", {m_adr_o, m_dat_o}, exp_q[rd_idx]);
               if (m_adr_o == BASE && m_dat_o[0]) kick = 1'b1;
               rd_idx++;
            end
         end
      end
   end
   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs", {wb_ack_o, wb_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, busy}, '0);
      rst_n = 1'b1;
      wb_xfer(1'b0, 4'd6, 32'h0, q); chk("status_reset", q, 32'h4);
      wb_xfer(1'b0, 4'd0, 32'h0, q); chk("x_reset", q, 32'h0);
      // single command
      stage(32'd16, 32'd8, 32'd32, 32'd4, 32'hFFFF_FFFF);
      wb_xfer(1'b0, 4'd2, 32'h0, q); chk("w_readback", q, 32'd32);
      wb_xfer(1'b0, 4'd5, 32'h0, q); chk("push_read_zero", q, 32'h0);
      wb_xfer(1'b0, 4'd9, 32'h0, q); chk("unmapped_read_zero", q, 32'h0);
      busy_len = 20; ack_lat = 0;
      push(32'h2);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin @(negedge clk); if (blit_busy) begin got = 1'b1; break; end end
      chk("blit_busy_rise", got, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin @(negedge clk); if (!blit_busy) begin got = 1'b1; break; end end
      chk("blit_busy_fall", got, 1'b1);
      chk("busy_still_high", busy, 1'b1);
      @(negedge clk); chk("busy_falls", busy, 1'b0);
      chk("single_writes", 32'(nwr), 32'd6);
      // queue of three, held off by the blitter
      hold_busy = 1'b1; ack_lat = 1; busy_len = 5;
      for (int i = 0; i < 3; i++) begin
         stage(32'(i * 32), $urandom, $urandom, $urandom, $urandom);
         push($urandom_range(0, 7));
      end
      wb_xfer(1'b0, 4'd6, 32'h0, q); chk("status_q3", q, stat_exp()); chk("count3", q[15:8], 8'd3);
      hold_busy = 1'b0;
      wait_idle(1000);
      wb_xfer(1'b0, 4'd6, 32'h0, q); chk("status_drained", q, stat_exp()); chk("count0", q[15:8], 8'd0);
      // overflow
      hold_busy = 1'b1; ack_lat = 7;
      for (int i = 0; i < DEPTH + 1; i++) begin
         stage($urandom, $urandom, $urandom, $urandom, $urandom);
         push($urandom_range(0, 7));
      end
      wb_xfer(1'b0, 4'd6, 32'h0, q); chk("status_ovf", q, stat_exp()); chk("status_ovf_bits", q, 32'h080B);
      wb_xfer(1'b1, 4'd6, 32'h8, q); movf = 1'b0;
      wb_xfer(1'b0, 4'd6, 32'h0, q); chk("status_ovf_clr", q, stat_exp()); chk("ovf_clr_bits", q, 32'h0803);
      snap = nwr; hold_busy = 1'b0; busy_len = $urandom_range(1, 6);
      wait_idle(4000);
      chk("ovf_issued", 32'(nwr - snap), 32'd48);
      // clipped-away commands: two-cycle busy pulse
      hold_busy = 1'b1; busy_len = 2; ack_lat = 0;
      stage($urandom, $urandom, $urandom, $urandom, $urandom); push(32'h4);
      stage($urandom, $urandom, $urandom, $urandom, $urandom); push(32'h6);
      hold_busy = 1'b0;
      wait_idle(1000);
      // random rounds, including re-pushes of unchanged staging
      for (int r = 0; r < 3; r++) begin
         ack_lat = $urandom_range(0, 4); busy_len = $urandom_range(1, 8);
         for (int j = 0; j < 6; j++) begin
            if ($urandom_range(0, 1) == 1) stage($urandom, $urandom, $urandom, $urandom, $urandom);
            push($urandom_range(0, 7));
         end
         wait_idle(3000);
      end
      // reset during the third write of a burst
      ack_lat = 2; busy_len = 4;
      stage($urandom, $urandom, $urandom, $urandom, $urandom); push(32'h2); push(32'h0);
      got = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (in_xfer && rd_idx % 6 == 2) begin got = 1'b1; break; end
      end
      chk("third_write_seen", got, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("async_drop", {m_cyc_o, m_stb_o}, 2'b00);
      snap = nwr; sx = '0; sy = '0; sw = '0; sh = '0; sp = '0; movf = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_writes_after_reset", 32'(nwr), 32'(snap));
      wb_xfer(1'b0, 4'd6, 32'h0, q); chk("status_after_reset", q, 32'h4);
      wb_xfer(1'b0, 4'd0, 32'h0, q); chk("x_after_reset", q, sx);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/gpu_blit_cmdq.md
Name: gpu_blit_cmdq

Overview:
- Command queue that sits directly upstream of the GPU blitter on the SOC Wishbone bus.
- The CPU stages a rectangle descriptor (x, y, width, height, pattern) and pushes it with a control word into a FIFO.
- A Wishbone master pops one entry at a time, programs the blitter's register window, starts it, and waits for blitter busy to fall before starting the next entry.
- The CPU can therefore queue glyph/fill work without polling the blitter itself.

Parameters:
- DEPTH, 8, number of queued commands (power of two, 2..64).
- BLIT_BASE, 32'h0, master address of blitter register 0; register n is at BLIT_BASE + n.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  slave cycle/strobe/write-enable.
- wb_sel_i  in  4  slave byte select (ignored; full-word access).
- wb_adr_i  in  32  slave address; word index is [3:0].
- wb_dat_i  in  32  slave write data.
- wb_ack_o  out  1  slave acknowledge.
- wb_dat_o  out  32  slave read data.
- m_cyc_o, m_stb_o, m_we_o  out  1 each  master cycle/strobe/write-enable.
- m_sel_o  out  4  master byte select.
- m_adr_o  out  32  master address.
- m_dat_o  out  32  master write data.
- m_ack_i  in  1  master acknowledge.
- blit_busy  in  1  busy output of the blitter.
- busy  out  1  high when queue is non-empty or a command is in flight.

Behaviour:
- Reset:
  - All outputs are 0; FIFO is empty; overflow is 0; staging registers are 0; state is IDLE.
  - Reset is asynchronous: mid-operation it drops m_cyc_o/m_stb_o immediately and discards all queued entries.
- Slave:
  - Ack is registered, one cycle after cyc&stb, and only when ack is not already high (single-cycle pulse, no back-to-back ack).
  - Register map by adr[3:0]:
    - 0 X, 1 Y, 2 W, 3 H, 4 PATTERN: read/write staging registers.
    - 5 PUSH: a write enqueues {X, Y, W, H, PATTERN, dat_i[2:1]} (bit1 fill, bit2 clip). Reads return 0.
    - 6 STATUS: read returns {16'h0, count[7:0], 4'h0, overflow, empty, full, busy}. Writing bit3=1 clears overflow.
    - Other addresses: reads return 0; writes are ignored.
- Push timing:
  - The entry is visible (count increments) the cycle after the accepting ack edge.
  - A push while full is still acked, but the entry is dropped, count is unchanged, and overflow is set (sticky).
  - A pop and a push in the same cycle: count is unchanged, both take effect. Full is evaluated before the pop.
- Master FSM states:
  - IDLE:
    - Go to LOAD when FIFO is not empty and blit_busy=0.
  - LOAD:
    - Pop the head into working registers.
    - Set reg index k=0 using sequence table seq[k] = (addr 2, X), (3, Y), (4, W), (5, H), (6, PATTERN), (0, {29'h0, clip, fill, 1'b1}).
    - Go to WR.
  - WR:
    - Drive m_cyc=m_stb=m_we=1, m_sel=4'hF, m_adr=BLIT_BASE+seq[k].addr, m_dat=seq[k].data.
    - Go to WAIT_ACK.
  - WAIT_ACK:
    - Hold all master outputs until m_ack_i.
    - On ack, drop cyc/stb/we the next edge.
    - If k<5: k+1 and go to WR (one idle bus cycle between transfers). If k=5: go to SETTLE.
  - SETTLE:
    - Wait exactly one cycle so blitter busy can assert; blit_busy is ignored here.
    - Go to WAIT_DONE.
  - WAIT_DONE:
    - Stay while blit_busy=1; go to IDLE when it is 0.
    - A short busy pulse (fully clipped command) must still complete.
- Master sequence properties:
  - Exactly 6 master writes per command, always in the order above. The start write is always last.
  - The master never reads.
  - No slave access stalls the master.
  - Staging registers are unaffected by push and pop, so repeated PUSH writes re-enqueue the same rectangle.
- Width rules:
  - count is clog2(DEPTH)+1 bits, zero-extended into STATUS[15:8].
  - Pointers wrap modulo DEPTH.
- busy = (count!=0) | (state!=IDLE).

Test Plan:
- Single command: write X=16, Y=8, W=32, H=4, PATTERN=FFFFFFFF, PUSH=0x2 -> master writes (BLIT_BASE+2,16), (+3,8), (+4,32), (+5,4), (+6,FFFFFFFF), (+0,0x3) in order. Model blit_busy high for 20 cycles -> busy falls 1 cycle after blit_busy falls.
- Queue of 3 with distinct X=0, 32, 64 -> three 6-write bursts in FIFO order. No burst starts while blit_busy=1. STATUS count reads 3 and then drains to 0.
- Overflow: DEPTH=8, blit_busy held high, 9 pushes -> all 9 acked, count=8, full=1, overflow=1. Write STATUS bit3 -> overflow=0. Release busy -> exactly 8 commands issued.
- Clipped-away command: blit_busy pulses high for 2 cycles after the start write -> FSM exits WAIT_DONE and the next queued command starts.
- Master ack latency: m_ack_i delayed 0, 1 and 7 cycles -> outputs held stable until ack, and each transfer has exactly one ack.
- Reset mid-burst: assert rst_n=0 during the third write -> m_cyc_o=0 asynchronously. After release, count=0, empty=1, and no further master writes occur.
